// File: rtl/tart_pkg.sv
// Shared types and sizing helpers for the visibility
// output path of the correlator.
package tart_pkg;

  localparam int DEF_ACCUM = 36;
  localparam int DEF_CORES = 18;
  localparam int DEF_TRATE = 30;

  typedef struct packed {
    logic [DEF_ACCUM-1:0] re;
    logic [DEF_ACCUM-1:0] im;
  } vis_word_t;

  typedef enum logic [1:0] {
    W_WAIT,
    W_FILL,
    W_DROP
  } wr_state_t;

  function automatic int total_words(
    input int cores,
    input int trate
  );
    return cores * trate;
  endfunction

endpackage

// File: rtl/vis_bank_ram.sv
// Two-bank simple dual-port visibility store with a
// registered read port.
module vis_bank_ram #(
  parameter int WORDS = 6,
  parameter int ABITS = 3,
  parameter int DW = 72
) (
  input  logic             vis_clock,
  input  logic             wr_en,
  input  logic [ABITS:0]   wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic             rd_en,
  input  logic [ABITS:0]   rd_addr,
  output logic [DW-1:0]    rd_data
);

  localparam int IW = $clog2(2 * WORDS);

  logic [DW-1:0] mem [2*WORDS];

  // Bank bit selects the upper half; the array stays exactly 2*WORDS deep.
  function automatic logic [IW-1:0] map(
    input logic [ABITS:0] a
  );
    if (a[ABITS])
      return IW'(WORDS) + IW'(a[ABITS-1:0]);
    return IW'(a[ABITS-1:0]);
  endfunction

  always_ff @(posedge vis_clock) begin
    if (wr_en)
      mem[map(wr_addr)] <= wr_data;
    if (rd_en)
      rd_data <= mem[map(rd_addr)];
  end

endmodule

// File: rtl/vis_pingpong_buffer.sv
// Ping-pong frame buffer between the visibility
// accumulator and the host AXI4-Stream.
module vis_pingpong_buffer
  import tart_pkg::*;
#(
  parameter int ACCUM = DEF_ACCUM,
  parameter int CORES = DEF_CORES,
  parameter int TRATE = DEF_TRATE
) (
  input  logic             vis_clock,
  input  logic             reset_n,
  input  logic             acc_valid_i,
  input  logic             acc_last_i,
  input  logic [ACCUM-1:0] acc_revis_i,
  input  logic [ACCUM-1:0] acc_imvis_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic             m_last_o,
  output logic [ACCUM-1:0] m_revis_o,
  output logic [ACCUM-1:0] m_imvis_o,
  output logic             frame_o,
  output logic             overflow_o,
  output logic             err_o,
  output logic [7:0]       drops_o
);

  localparam int TOTAL = total_words(CORES, TRATE);
  localparam int ABITS = $clog2(TOTAL);
  localparam int DW = 2 * ACCUM;
  localparam logic [ABITS-1:0] LAST_A = ABITS'(TOTAL - 1);

  wr_state_t state, state_n;
  logic [ABITS-1:0] wptr, wptr_n;
  logic wbank, rbank;
  logic [1:0] full, full_n;
  logic fill, good, bad, lost, clr;

  logic ibank, rvalid, rlast, issue, ilast, pop;
  logic [ABITS-1:0] iaddr;
  logic [1:0] occ;
  logic [DW-1:0] rdata, odata, sdata;
  logic svalid, slast;

  always_ff @(posedge vis_clock) begin
    if (!reset_n)
      state <= W_WAIT;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    wptr_n = wptr;
    good = 1'b0;
    bad = 1'b0;
    lost = 1'b0;
    fill = (state == W_FILL) ||
           (state == W_WAIT && !full[wbank]);
    if (acc_valid_i) begin
      if (wptr == LAST_A || acc_last_i) begin
        state_n = W_WAIT;
        wptr_n = '0;
        good = fill && wptr == LAST_A && acc_last_i;
        bad = !(wptr == LAST_A && acc_last_i);
        lost = !fill;
      end else begin
        wptr_n = wptr + ABITS'(1);
        state_n = fill ? W_FILL : W_DROP;
      end
    end
  end

  // A same-cycle clear is invisible to the writer this cycle.
  always_comb begin
    full_n = full;
    if (clr)
      full_n[rbank] = 1'b0;
    if (good)
      full_n[wbank] = 1'b1;
  end

  always_ff @(posedge vis_clock) begin
    if (!reset_n) begin
      wptr <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      full <= '0;
      frame_o <= 1'b0;
      err_o <= 1'b0;
      overflow_o <= 1'b0;
      drops_o <= '0;
    end else begin
      wptr <= wptr_n;
      wbank <= wbank ^ good;
      rbank <= rbank ^ clr;
      full <= full_n;
      frame_o <= good;
      err_o <= err_o | bad;
      overflow_o <= overflow_o | lost;
      if (lost && drops_o != 8'hFF)
        drops_o <= drops_o + 8'd1;
    end
  end

  vis_bank_ram #(
    .WORDS(TOTAL),
    .ABITS(ABITS),
    .DW(DW)
  ) u_ram (
    .vis_clock(vis_clock),
    .wr_en(acc_valid_i && fill),
    .wr_addr({wbank, wptr}),
    .wr_data({acc_revis_i, acc_imvis_i}),
    .rd_en(issue),
    .rd_addr({ibank, iaddr}),
    .rd_data(rdata)
  );

  assign pop = m_valid_o && m_ready_i;
  assign clr = pop && m_last_o;
  assign occ = {1'b0, m_valid_o} + {1'b0, svalid} +
               {1'b0, rvalid};
  assign ilast = iaddr == LAST_A;
  // Count the beat leaving this cycle so reads never bubble.
  assign issue = full[ibank] && (occ < 2'd2 || pop);

  always_ff @(posedge vis_clock) begin
    if (!reset_n) begin
      ibank <= 1'b0;
      iaddr <= '0;
      rvalid <= 1'b0;
      rlast <= 1'b0;
    end else begin
      rvalid <= issue;
      rlast <= issue && ilast;
      if (issue) begin
        iaddr <= ilast ? '0 : iaddr + ABITS'(1);
        ibank <= ibank ^ ilast;
      end
    end
  end

  always_ff @(posedge vis_clock) begin
    if (!reset_n) begin
      m_valid_o <= 1'b0;
      m_last_o <= 1'b0;
      odata <= '0;
      svalid <= 1'b0;
      slast <= 1'b0;
      sdata <= '0;
    end else if (!m_valid_o || pop) begin
      if (svalid) begin
        m_valid_o <= 1'b1;
        m_last_o <= slast;
        odata <= sdata;
        svalid <= rvalid;
        slast <= rlast;
        sdata <= rdata;
      end else begin
        m_valid_o <= rvalid;
        m_last_o <= rlast;
        if (rvalid)
          odata <= rdata;
      end
    end else if (rvalid) begin
      svalid <= 1'b1;
      slast <= rlast;
      sdata <= rdata;
    end
  end

  assign m_revis_o = odata[DW-1:ACCUM];
  assign m_imvis_o = odata[ACCUM-1:0];

endmodule

// File: tb/tb_vis_pingpong_buffer.sv
// Directed bench for vis_pingpong_buffer with a
// six-word frame (CORES=2, TRATE=3).
module tb_vis_pingpong_buffer;

  localparam int AW = 36;

  logic vis_clock = 1'b0;
  logic reset_n = 1'b0;
  logic acc_valid_i = 1'b0;
  logic acc_last_i = 1'b0;
  logic [AW-1:0] acc_revis_i = '0;
  logic [AW-1:0] acc_imvis_i = '0;
  logic m_ready_i = 1'b0;
  logic m_valid_o, m_last_o, frame_o;
  logic overflow_o, err_o;
  logic [AW-1:0] m_revis_o, m_imvis_o;
  logic [7:0] drops_o;

  int vec = 0;
  int miss = 0;
  int cyc = 0;

  logic [AW-1:0] re_q[$];
  logic [AW-1:0] im_q[$];
  logic last_q[$];
  int cyc_q[$];
  int frm_q[$];
  int vr_q[$];
  int stab_err = 0;
  logic prev_valid = 1'b0;
  logic prev_stall = 1'b0;
  logic [2*AW:0] prev_pay = '0;

  vis_pingpong_buffer #(
    .ACCUM(AW),
    .CORES(2),
    .TRATE(3)
  ) dut (
    .vis_clock(vis_clock),
    .reset_n(reset_n),
    .acc_valid_i(acc_valid_i),
    .acc_last_i(acc_last_i),
    .acc_revis_i(acc_revis_i),
    .acc_imvis_i(acc_imvis_i),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i),
    .m_last_o(m_last_o),
    .m_revis_o(m_revis_o),
    .m_imvis_o(m_imvis_o),
    .frame_o(frame_o),
    .overflow_o(overflow_o),
    .err_o(err_o),
    .drops_o(drops_o)
  );

  always #5 vis_clock = ~vis_clock;

  always @(posedge vis_clock) cyc <= cyc + 1;

  always @(negedge vis_clock) begin
    if (frame_o)
      frm_q.push_back(cyc);
    if (m_valid_o && !prev_valid)
      vr_q.push_back(cyc);
    if (reset_n && prev_stall &&
        (!m_valid_o ||
         {m_last_o, m_revis_o, m_imvis_o} !== prev_pay))
      stab_err++;
    if (m_valid_o && m_ready_i) begin
      re_q.push_back(m_revis_o);
      im_q.push_back(m_imvis_o);
      last_q.push_back(m_last_o);
      cyc_q.push_back(cyc);
    end
    prev_valid = m_valid_o;
    prev_stall = m_valid_o && !m_ready_i;
    prev_pay = {m_last_o, m_revis_o, m_imvis_o};
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge vis_clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    acc_valid_i = 1'b0;
    acc_last_i = 1'b0;
    m_ready_i = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic send_frame(
    input int base,
    input int n,
    input int lastk
  );
    for (int k = 0; k < n; k++) begin
      acc_valid_i = 1'b1;
      acc_revis_i = AW'(base + k);
      acc_imvis_i = AW'(-(base + k));
      acc_last_i = (k == lastk);
      tick();
    end
    acc_valid_i = 1'b0;
    acc_last_i = 1'b0;
  endtask

  task automatic wait_beats(input int target, input int budget);
    for (int i = 0; i < budget && re_q.size() < target; i++)
      tick();
  endtask

  task automatic test_reset();
    do_reset();
    vec++;
    if ({m_valid_o, m_last_o, frame_o, overflow_o,
         err_o, drops_o} !== 13'd0) begin
      miss++;
      $display("FAIL reset_ctrl: got v=%b l=%b f=%b o=%b e=%b d=%0d, want all 0",
               m_valid_o, m_last_o, frame_o, overflow_o,
               err_o, drops_o);
    end
    vec++;
    if ({m_revis_o, m_imvis_o} !== '0) begin
      miss++;
      $display("FAIL reset_payload: got re=%0h im=%0h, want 0 0",
               m_revis_o, m_imvis_o);
    end
  endtask

  task automatic test_single_frame();
    int b, fb, vb, lat, span;
    logic [AW-1:0] gr, gi;
    logic gl;
    do_reset();
    m_ready_i = 1'b1;
    b = re_q.size();
    fb = frm_q.size();
    vb = vr_q.size();
    send_frame(0, 6, 5);
    wait_beats(b + 6, 40);
    repeat (4) tick();
    vec++;
    if (re_q.size() - b != 6) begin
      miss++;
      $display("FAIL single_count: got %0d beats, want 6",
               re_q.size() - b);
    end
    for (int i = 0; i < 6; i++) begin
      gr = (b + i < re_q.size()) ? re_q[b+i] : 'x;
      gi = (b + i < im_q.size()) ? im_q[b+i] : 'x;
      gl = (b + i < last_q.size()) ? last_q[b+i] : 1'bx;
      vec++;
      if (gr !== AW'(i) || gi !== AW'(-i) || gl !== (i == 5)) begin
        miss++;
        $display("FAIL single_beat%0d: got re=%0h im=%0h last=%b, want re=%0h im=%0h last=%b",
                 i, gr, gi, gl, AW'(i), AW'(-i), i == 5);
      end
    end
    vec++;
    if (frm_q.size() - fb != 1) begin
      miss++;
      $display("FAIL single_frame_pulse: got %0d pulses, want 1",
               frm_q.size() - fb);
    end
    lat = (vr_q.size() > vb && frm_q.size() > fb) ?
          vr_q[vb] - frm_q[fb] : -1;
    vec++;
    if (lat != 2) begin
      miss++;
      $display("FAIL single_latency: got %0d cycles, want 2", lat);
    end
    span = (cyc_q.size() >= b + 6) ? cyc_q[b+5] - cyc_q[b] : -1;
    vec++;
    if (span != 5) begin
      miss++;
      $display("FAIL single_rate: got span %0d cycles, want 5", span);
    end
  endtask

  task automatic test_stall();
    int b, s0, nlast;
    logic [AW-1:0] gr;
    do_reset();
    b = re_q.size();
    s0 = stab_err;
    send_frame(0, 6, 5);
    repeat (3) tick();
    for (int i = 0; i < 60 && re_q.size() < b + 6; i++) begin
      m_ready_i = (i % 3 == 0);
      tick();
    end
    m_ready_i = 1'b1;
    repeat (6) tick();
    vec++;
    if (re_q.size() - b != 6) begin
      miss++;
      $display("FAIL stall_count: got %0d beats, want 6",
               re_q.size() - b);
    end
    nlast = 0;
    for (int i = 0; i < 6; i++) begin
      gr = (b + i < re_q.size()) ? re_q[b+i] : 'x;
      if (b + i < last_q.size() && last_q[b+i])
        nlast++;
      vec++;
      if (gr !== AW'(i)) begin
        miss++;
        $display("FAIL stall_beat%0d: got re=%0h, want %0h",
                 i, gr, AW'(i));
      end
    end
    vec++;
    if (nlast != 1) begin
      miss++;
      $display("FAIL stall_last: got %0d last beats, want 1", nlast);
    end
    vec++;
    if (stab_err != s0) begin
      miss++;
      $display("FAIL stall_hold: got %0d payload changes while stalled, want 0",
               stab_err - s0);
    end
  endtask

  task automatic test_back_to_back();
    int b, fb, span;
    logic [AW-1:0] gr, er;
    logic gl;
    do_reset();
    b = re_q.size();
    fb = frm_q.size();
    send_frame(0, 6, 5);
    send_frame(10, 6, 5);
    send_frame(20, 6, 5);
    repeat (3) tick();
    vec++;
    if ({overflow_o, err_o, drops_o} !== {1'b1, 1'b0, 8'd1}) begin
      miss++;
      $display("FAIL b2b_flags: got ovf=%b err=%b drops=%0d, want 1 0 1",
               overflow_o, err_o, drops_o);
    end
    vec++;
    if (frm_q.size() - fb != 2 || re_q.size() != b) begin
      miss++;
      $display("FAIL b2b_commit: got %0d frames %0d beats, want 2 0",
               frm_q.size() - fb, re_q.size() - b);
    end
    m_ready_i = 1'b1;
    wait_beats(b + 12, 40);
    repeat (4) tick();
    vec++;
    if (re_q.size() - b != 12) begin
      miss++;
      $display("FAIL b2b_count: got %0d beats, want 12",
               re_q.size() - b);
    end
    for (int i = 0; i < 12; i++) begin
      er = (i < 6) ? AW'(i) : AW'(4 + i);
      gr = (b + i < re_q.size()) ? re_q[b+i] : 'x;
      gl = (b + i < last_q.size()) ? last_q[b+i] : 1'bx;
      vec++;
      if (gr !== er || gl !== (i == 5 || i == 11)) begin
        miss++;
        $display("FAIL b2b_beat%0d: got re=%0h last=%b, want re=%0h last=%b",
                 i, gr, gl, er, i == 5 || i == 11);
      end
    end
    span = (cyc_q.size() >= b + 12) ? cyc_q[b+11] - cyc_q[b] : -1;
    vec++;
    if (span != 11) begin
      miss++;
      $display("FAIL b2b_gap: got span %0d cycles, want 11", span);
    end
  endtask

  task automatic test_misframe();
    int b, fb;
    logic [AW-1:0] gr;
    do_reset();
    m_ready_i = 1'b1;
    b = re_q.size();
    fb = frm_q.size();
    send_frame(0, 4, 3);
    repeat (8) tick();
    vec++;
    if ({err_o, overflow_o, drops_o} !== {1'b1, 1'b0, 8'd0}) begin
      miss++;
      $display("FAIL misframe_flags: got err=%b ovf=%b drops=%0d, want 1 0 0",
               err_o, overflow_o, drops_o);
    end
    vec++;
    if (re_q.size() != b || frm_q.size() != fb) begin
      miss++;
      $display("FAIL misframe_silent: got %0d beats %0d frames, want 0 0",
               re_q.size() - b, frm_q.size() - fb);
    end
    send_frame(40, 6, 5);
    wait_beats(b + 6, 40);
    repeat (3) tick();
    vec++;
    if (re_q.size() - b != 6) begin
      miss++;
      $display("FAIL misframe_next_count: got %0d beats, want 6",
               re_q.size() - b);
    end
    for (int i = 0; i < 6; i++) begin
      gr = (b + i < re_q.size()) ? re_q[b+i] : 'x;
      vec++;
      if (gr !== AW'(40 + i)) begin
        miss++;
        $display("FAIL misframe_next_beat%0d: got re=%0h, want %0h",
                 i, gr, AW'(40 + i));
      end
    end
  endtask

  task automatic test_reset_mid();
    int b;
    logic [AW-1:0] gr, gi;
    do_reset();
    m_ready_i = 1'b1;
    send_frame(0, 2, 1);
    b = re_q.size();
    send_frame(0, 6, 5);
    wait_beats(b + 2, 40);
    vec++;
    if (!(m_valid_o === 1'b1 && m_revis_o === AW'(2))) begin
      miss++;
      $display("FAIL rstmid_beat3: got v=%b re=%0h, want 1 2",
               m_valid_o, m_revis_o);
    end
    reset_n = 1'b0;
    tick();
    vec++;
    if ({m_valid_o, m_last_o, frame_o, overflow_o, err_o,
         drops_o, m_revis_o, m_imvis_o} !== '0) begin
      miss++;
      $display("FAIL rstmid_clear: got v=%b l=%b e=%b o=%b d=%0d re=%0h, want all 0",
               m_valid_o, m_last_o, err_o, overflow_o, drops_o,
               m_revis_o);
    end
    reset_n = 1'b1;
    tick();
    b = re_q.size();
    send_frame(60, 6, 5);
    wait_beats(b + 6, 40);
    repeat (3) tick();
    vec++;
    if (re_q.size() - b != 6) begin
      miss++;
      $display("FAIL rstmid_next_count: got %0d beats, want 6",
               re_q.size() - b);
    end
    for (int i = 0; i < 6; i++) begin
      gr = (b + i < re_q.size()) ? re_q[b+i] : 'x;
      gi = (b + i < im_q.size()) ? im_q[b+i] : 'x;
      vec++;
      if (gr !== AW'(60 + i) || gi !== AW'(-(60 + i))) begin
        miss++;
        $display("FAIL rstmid_next_beat%0d: got re=%0h im=%0h, want %0h %0h",
                 i, gr, gi, AW'(60 + i), AW'(-(60 + i)));
      end
    end
  endtask

  task automatic test_clear_collision();
    int b, fb;
    logic [AW-1:0] g5, g6, g11;
    do_reset();
    b = re_q.size();
    fb = frm_q.size();
    send_frame(100, 6, 5);
    send_frame(200, 6, 5);
    repeat (4) tick();
    m_ready_i = 1'b1;
    repeat (5) tick();
    vec++;
    if (!(m_valid_o === 1'b1 && m_last_o === 1'b1 &&
          m_revis_o === AW'(105))) begin
      miss++;
      $display("FAIL collide_align: got v=%b l=%b re=%0h, want 1 1 105",
               m_valid_o, m_last_o, m_revis_o);
    end
    send_frame(300, 6, 5);
    wait_beats(b + 12, 40);
    repeat (6) tick();
    vec++;
    if ({overflow_o, err_o, drops_o} !== {1'b1, 1'b0, 8'd1}) begin
      miss++;
      $display("FAIL collide_flags: got ovf=%b err=%b drops=%0d, want 1 0 1",
               overflow_o, err_o, drops_o);
    end
    vec++;
    if (re_q.size() - b != 12 || frm_q.size() - fb != 2) begin
      miss++;
      $display("FAIL collide_count: got %0d beats %0d frames, want 12 2",
               re_q.size() - b, frm_q.size() - fb);
    end
    g5 = (b + 5 < re_q.size()) ? re_q[b+5] : 'x;
    g6 = (b + 6 < re_q.size()) ? re_q[b+6] : 'x;
    g11 = (b + 11 < re_q.size()) ? re_q[b+11] : 'x;
    vec++;
    if (g5 !== AW'(105) || g6 !== AW'(200) || g11 !== AW'(205)) begin
      miss++;
      $display("FAIL collide_order: got %0h %0h %0h, want 105 200 205",
               g5, g6, g11);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_stall();
    test_back_to_back();
    test_misframe();
    test_reset_mid();
    test_clear_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/vis_pingpong_buffer.md
# vis_pingpong_buffer

Double-banked output buffer between the final-stage visibility accumulator and the host-facing stream, entirely in the `vis_clock` domain. It collects one full frame of `CORES*TRATE` accumulated complex visibilities into one of two SRAM banks, then streams the completed bank out over AXI4-Stream while the other bank fills. Overflow and framing errors are reported. Clock-domain crossing to the bus domain is handled by a separate downstream FIFO.

## Interface
- `ACCUM`, 36, bit-width of each real/imag visibility
- `CORES`, 18, correlator cores
- `TRATE`, 30, time-multiplexing rate
- `TOTAL`, `CORES*TRATE` (local), words per frame
- `ABITS`, `$clog2(TOTAL)` (local), word-address width
- `vis_clock`  in  1  all logic, rising edge
- `reset_n`  in  1  synchronous, active-low
- `acc_valid_i`  in  1  input word valid; no backpressure upstream
- `acc_last_i`  in  1  final word of a frame
- `acc_revis_i`, `acc_imvis_i`  in  ACCUM  visibility word
- `m_valid_o`  out  1  AXI4-Stream valid
- `m_ready_i`  in  1  AXI4-Stream ready
- `m_last_o`  out  1  final beat of a frame
- `m_revis_o`, `m_imvis_o`  out  ACCUM  streamed word
- `frame_o`  out  1  one-cycle pulse when a bank is committed full
- `overflow_o`  out  1  sticky: a frame was dropped because no bank was free
- `err_o`  out  1  sticky: `acc_last_i` was misplaced
- `drops_o`  out  8  dropped-frame count, saturating at 255

## Operation
- Reset values: all outputs 0; both bank-full flags 0; write bank 0; read bank 0; `wptr` 0.
- Writer FSM states:
  - WAIT: `wptr`=0. On `acc_valid_i`, if `full[wbank]` then go to DROP, else write word 0 and go to FILL.
  - FILL: write `{wbank,wptr}`, then increment `wptr`.
  - DROP: discard words until the frame ends.
- Frame end is `acc_valid_i` with `wptr==TOTAL-1` or with `acc_last_i`.
  - Good end (FILL, `wptr==TOTAL-1`, `acc_last_i`=1): write the word, set `full[wbank]`, toggle `wbank`, pulse `frame_o`, reset `wptr`=0, go to WAIT.
  - Misplaced `acc_last_i` (`wptr!=TOTAL-1`), or missing `acc_last_i` at `TOTAL-1`: set `err_o`, do not set the full flag, keep `wbank`, reset `wptr`=0, go to WAIT.
  - DROP end: set `overflow_o`, increment `drops_o` (saturating), go to WAIT.
  - A frame that both overflows and misframes sets both flags.
- Reader:
  - Streams bank `rbank` when `full[rbank]`, in address order 0..TOTAL-1.
  - `m_last_o` is asserted on beat `TOTAL-1`.
  - The `m_last_o` handshake clears `full[rbank]` and toggles `rbank`.
- Full flags are registered. A clear from the reader and a WAIT-state check by the writer in the same cycle: the writer sees the old value (full), so that frame is dropped. This is deterministic and required.
- AXI rules:
  - Once asserted, `m_valid_o` and the payload hold until `m_ready_i`.
  - No combinational path from `m_ready_i` to `m_valid_o`.
- Reset mid-operation discards both banks and any in-flight frame. The next `acc_valid_i` after reset is treated as word 0.

## Timing
- Write: one word per cycle, zero stall; the SRAM write occurs on the same edge as `acc_valid_i`.
- `frame_o` is high in the cycle after the last-word edge.
- First-beat latency: `m_valid_o` rises 2 cycles after the edge that sets the full flag (1 cycle SRAM read + 1 output register).
- Throughput: sustained 1 beat/cycle with `m_ready_i`=1, including across the bank switch when the other bank is already full (no bubble).
- Reader: 1-cycle registered SRAM read plus a 2-entry skid/output buffer. The read address advances when the skid buffer has space.

## Structure
- Shared package `tart_pkg`:
  - `ACCUM` default.
  - `vis_word_t` packed `{re, im}` (`2*ACCUM` bits).
  - Frame-size function `total_words(CORES, TRATE)`.
- Sub-module `vis_bank_ram`: simple dual-port, depth `2*TOTAL`, width `2*ACCUM`, sync write, registered read, address `{bank, word}`.
- Writer FSM, reader/skid logic and flags all live in `vis_pingpong_buffer`.

## Test plan
All scenarios use `CORES`=2, `TRATE`=3, so `TOTAL`=6.
- One frame, re=k, im=-k for k=0..5, last on k=5, `m_ready_i`=1 → 6 beats in order, `m_last_o` on re=5, first `m_valid_o` 2 cycles after the full flag is set, `frame_o` pulse ×1.
- Same frame with `m_ready_i` toggling 1,0,0,1,… → payload stable while stalled, no loss or duplication, exactly one `m_last_o`.
- Three back-to-back frames with `m_ready_i`=0 → frames 1–2 buffered, frame 3 dropped, `overflow_o`=1, `drops_o`=1. Then ready=1 → frame 1 then frame 2, 12 beats with no gap.
- `acc_last_i` at k=3 → `err_o`=1, nothing streamed, `wbank` unchanged. The next correct frame is streamed normally from bank 0.
- Reset pulse during the 3rd output beat → the next cycle all outputs are 0 and flags are cleared. A following frame streams correctly from bank 0.
- Reader's `m_last_o` handshake in the same cycle as a new frame's word 0 targeting that bank → frame dropped, `drops_o` increments.
